// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the iterative multiply/divide unit.
//   mdu_op_t    - 4-bit MDU operation code
//   mdu_state_t - sequencer state (idle, multiply in flight, divide in flight)
//   is_mul_op / is_div_op / is_signed_op - operation classification
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

   typedef enum logic [3:0] {
      NONE  = 4'd0,
      MULT  = 4'd1,
      MULTU = 4'd2,
      DIV   = 4'd3,
      DIVU  = 4'd4,
      MFHI  = 4'd5,
      MFLO  = 4'd6,
      MTHI  = 4'd7,
      MTLO  = 4'd8,
      MADD  = 4'd9,
      MADDU = 4'd10,
      MSUB  = 4'd11,
      MSUBU = 4'd12
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_t;

   // Multiply-class ops; the accumulate forms only exist when enabled,
   // otherwise their codes fall through and behave like NONE.
   function automatic logic is_mul_op(mdu_op_t op);
`ifdef MDU_MADD_EN
      return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
`else
      return op inside {MULT, MULTU};
`endif
   endfunction

   function automatic logic is_div_op(mdu_op_t op);
      return op inside {DIV, DIVU};
   endfunction

   function automatic logic is_signed_op(mdu_op_t op);
      return op inside {MULT, MADD, MSUB, DIV};
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, reset        - clock, synchronous active-high reset
//   load              - start a division with dividend/divisor
//   dividend, divisor - unsigned operands, sampled when load is high
//   quo, rem          - quotient / remainder, final WIDTH cycles after load
// The load edge already performs the first iteration, so after the edge
// closing cycle t0+WIDTH-1 the registers hold the finished result.
import mdu_pkg::*;

module mdu_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem
);

   logic [WIDTH-1:0] rem_q, quo_q, div_q;
   logic [WIDTH-1:0] src_rem, src_quo, src_div;
   logic [WIDTH:0]   shifted, diff;
   logic [WIDTH-1:0] next_rem, next_quo;

   always_comb begin
      src_rem  = load ? '0       : rem_q;
      src_quo  = load ? dividend : quo_q;
      src_div  = load ? divisor  : div_q;
      shifted  = {src_rem, src_quo[WIDTH-1]};
      diff     = shifted - {1'b0, src_div};
      // diff[WIDTH] is the borrow: restore the partial remainder when set.
      next_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      next_quo = {src_quo[WIDTH-2:0], ~diff[WIDTH]};
   end

   // The array keeps iterating after completion; the owner samples the
   // result on the exact commit edge, so the extra steps are harmless.
   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         div_q <= '0;
      end else begin
         rem_q <= next_rem;
         quo_q <= next_quo;
         if (load) div_q <= divisor;
      end
   end

   assign quo = quo_q;
   assign rem = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit with HI/LO registers.
//   clk, reset - clock, synchronous active-high reset
//   start      - issue strobe for op
//   cancel     - kills this cycle's issue (never an op already in flight)
//   op         - mdu_op_t operation code
//   rs, rt     - operands (latched at issue)
//   busy       - long operation in flight
//   md_out     - HI for MFHI, LO for MFLO, else 0 (combinational)
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract ops).
import mdu_pkg::*;

module mdu_iter #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cancel,
   input  mdu_op_t          op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic [WIDTH-1:0] md_out
);

   localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   mdu_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [2*WIDTH-1:0] prod_q;
   mdu_op_t            op_q;
   logic               neg_quo_q, neg_rem_q, div_zero_q;
   logic [WIDTH-1:0]   rs_q;

   logic               issue, sgn, done;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
   logic [WIDTH-1:0]   abs_rs, abs_rt, quo, rem, div_lo, div_hi;

   assign issue = start && !cancel && (state_q == ST_IDLE);
   assign sgn   = is_signed_op(op);
   assign done  = (state_q != ST_IDLE) && (cnt_q == CNT_W'(1));

   // Issue-time datapath: full product and divider operand magnitudes
   always_comb begin
      ext_a  = sgn ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
      ext_b  = sgn ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
      prod   = ext_a * ext_b;
      abs_rs = (sgn && rs[WIDTH-1]) ? -rs : rs;
      abs_rt = (sgn && rt[WIDTH-1]) ? -rt : rt;
   end

   mdu_divider #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (issue && is_div_op(op)),
      .dividend (abs_rs),
      .divisor  (abs_rt),
      .quo      (quo),
      .rem      (rem)
   );

   // Commit-time result selection
   always_comb begin
`ifdef MDU_MADD_EN
      case (op_q)
         MADD, MADDU: mul_res = {hi_q, lo_q} + prod_q;
         MSUB, MSUBU: mul_res = {hi_q, lo_q} - prod_q;
         default:     mul_res = prod_q;
      endcase
`else
      mul_res = prod_q;
`endif
      // MIN / -1 needs no special path: |MIN| / 1 = MIN unsigned, and
      // negating MIN yields MIN with a zero remainder.
      if (div_zero_q) begin
         div_lo = '1;
         div_hi = rs_q;
      end else begin
         div_lo = neg_quo_q ? -quo : quo;
         div_hi = neg_rem_q ? -rem : rem;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (issue && is_mul_op(op))      state_d = ST_MUL;
            else if (issue && is_div_op(op)) state_d = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         if (issue && is_mul_op(op))      cnt_q <= CNT_W'(MUL_LAT);
         else if (issue && is_div_op(op)) cnt_q <= CNT_W'(WIDTH);
         else if (cnt_q != '0)            cnt_q <= cnt_q - 1'b1;

         if (issue && op == MTHI) hi_q <= rs;
         if (issue && op == MTLO) lo_q <= rs;

         if (done && state_q == ST_MUL) begin
            {hi_q, lo_q} <= mul_res;
         end else if (done && state_q == ST_DIV) begin
            hi_q <= div_hi;
            lo_q <= div_lo;
         end
      end
   end

   // Operand latches for the op in flight; only meaningful after an issue
   always_ff @(posedge clk) begin
      if (issue) begin
         op_q       <= op;
         prod_q     <= prod;
         rs_q       <= rs;
         neg_quo_q  <= sgn && (rs[WIDTH-1] ^ rt[WIDTH-1]);
         neg_rem_q  <= sgn && rs[WIDTH-1];
         div_zero_q <= (rt == '0);
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign md_out = (op == MFHI) ? hi_q : (op == MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed bench for mdu_iter (WIDTH=32, MUL_LAT=5) with a
// scoreboard of expected HI:LO results. MDU_MADD_EN selects the
// accumulate checks or the treated-as-NONE checks.
import mdu_pkg::*;

module tb_mdu_iter;

   localparam int W  = 32;
   localparam int ML = 5;

   logic          clk = 1'b0;
   logic          reset, start, cancel;
   mdu_op_t       op;
   logic [W-1:0]  rs, rt;
   logic          busy;
   logic [W-1:0]  md_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [63:0] hilo;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] m_hilo;

   mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .cancel (cancel),
      .op     (op),
      .rs     (rs),
      .rt     (rt),
      .busy   (busy),
      .md_out (md_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reads committed HI:LO through md_out, with start low.
   task automatic read_hilo(output logic [63:0] v);
      op = MFHI;
      #1 v[63:32] = md_out;
      op = MFLO;
      #1 v[31:0] = md_out;
      op = NONE;
      #1;
   endtask

   function automatic logic [63:0] ref_op(mdu_op_t o, logic [31:0] a, logic [31:0] b,
                                          logic [63:0] acc);
      longint      xa, xb;
      int          ia, ib;
      logic [63:0] up, sp;
      xa = $signed(a);
      xb = $signed(b);
      ia = $signed(a);
      ib = $signed(b);
      up = {32'b0, a} * {32'b0, b};
      sp = 64'(xa * xb);
      case (o)
         MULT:  return sp;
         MULTU: return up;
         MADD:  return acc + sp;
         MADDU: return acc + up;
         MSUB:  return acc - sp;
         MSUBU: return acc - up;
         DIV: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(ia % ib), 32'(ia / ib)};
         end
         DIVU: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return acc;
      endcase
   endfunction

   // Drives one issue cycle; returns in the low phase of cycle t0+1 with
   // operands scrambled so a late operand read would be visible.
   task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic c);
      @(negedge clk);
      start  = 1'b1;
      cancel = c;
      op     = o;
      rs     = a;
      rt     = b;
      @(negedge clk);
      start  = 1'b0;
      cancel = 1'b0;
      op     = NONE;
      rs     = $urandom;
      rt     = $urandom;
   endtask

   // mode 0: plain; 1: cancel pulse in busy cycle 'at'; 2: start (another
   // long op) in busy cycle 'at', which must be ignored.
   task automatic run_long(input string tag, input mdu_op_t o, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input int mode, input int at);
      int          n;
      logic [63:0] v;
      exp_t        e;
      sbq.push_back('{tag, ref_op(o, a, b, m_hilo)});
      issue(o, a, b, 1'b0);
      n = 0;
      while (busy && n < 200) begin
         n++;
         if (mode == 1 && n == at) cancel = 1'b1;
         if (mode == 2 && n == at) begin
            start = 1'b1;
            op    = o;
            rs    = 32'd7;
            rt    = 32'd9;
         end
         @(negedge clk);
         start  = 1'b0;
         cancel = 1'b0;
         op     = NONE;
      end
      check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
      read_hilo(v);
      e = sbq.pop_front();
      check(e.tag, v, e.hilo);
      m_hilo = e.hilo;
   endtask

   initial begin
      logic [63:0] v;
      reset  = 1'b1;
      start  = 1'b0;
      cancel = 1'b0;
      op     = NONE;
      rs     = '0;
      rt     = '0;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      m_hilo = '0;
      check("reset_busy", 64'(busy), 64'(0));
      read_hilo(v);
      check("reset_hilo", v, m_hilo);

      // MTHI then MFLO/MFHI
      issue(MTHI, 32'h1234, 32'h0, 1'b0);
      check("mthi_busy", 64'(busy), 64'(0));
      m_hilo[63:32] = 32'h1234;
      read_hilo(v);
      check("mthi_hilo", v, m_hilo);

      // Multiplies
      run_long("mult_m2x3",  MULT,  32'hFFFF_FFFE, 32'd3, ML, 0, 0);
      run_long("multu_m2x3", MULTU, 32'hFFFF_FFFE, 32'd3, ML, 0, 0);
      run_long("mult_mix",   MULT,  32'h7FFF_FFFF, 32'h8000_0001, ML, 0, 0);

      // Divides
      run_long("div_m7_2",     DIV,  32'hFFFF_FFF9, 32'd2, W, 0, 0);
      run_long("divu_100_0",   DIVU, 32'd100, 32'd0, W, 0, 0);
      run_long("div_min_m1",   DIV,  32'h8000_0000, 32'hFFFF_FFFF, W, 0, 0);
      run_long("div_m5_0",     DIV,  32'hFFFF_FFFB, 32'd0, W, 0, 0);
      run_long("div_100_m7",   DIV,  32'd100, 32'hFFFF_FFF9, W, 0, 0);
      run_long("divu_big",     DIVU, 32'hFFFF_FFF0, 32'd10, W, 0, 0);

      // Issue killed in the same cycle
      issue(MULT, 32'd6, 32'd7, 1'b1);
      check("cancel_mult_busy", 64'(busy), 64'(0));
      read_hilo(v);
      check("cancel_mult_hilo", v, m_hilo);
      issue(MTLO, 32'd5, 32'd0, 1'b1);
      check("cancel_mtlo_busy", 64'(busy), 64'(0));
      read_hilo(v);
      check("cancel_mtlo_hilo", v, m_hilo);

      // Cancel mid-flight never affects an in-flight op
      run_long("div_cancel_mid", DIV, 32'd1000, 32'd7, W, 1, 3);

      // Start while busy is ignored
      run_long("mult_start_busy", MULT, 32'd11, 32'd13, ML, 2, 2);
      run_long("divu_start_busy", DIVU, 32'd500, 32'd3, W, 2, 10);

      // Reset during cycle 3 of a divide
      issue(DIV, 32'd77, 32'd5, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hilo = '0;
      check("reset_mid_busy", 64'(busy), 64'(0));
      read_hilo(v);
      check("reset_mid_hilo", v, m_hilo);
      @(negedge clk);
      check("reset_mid_busy_after", 64'(busy), 64'(0));

      // Accumulate ops
      issue(MTHI, 32'd0, 32'd0, 1'b0);
      issue(MTLO, 32'd10, 32'd0, 1'b0);
      m_hilo = {32'd0, 32'd10};
`ifdef MDU_MADD_EN
      run_long("madd_3x4",   MADD,  32'd3, 32'd4, ML, 0, 0);
      run_long("msubu_5x5",  MSUBU, 32'd5, 32'd5, ML, 0, 0);
      run_long("msub_m2x3",  MSUB,  32'hFFFF_FFFE, 32'd3, ML, 0, 0);
      run_long("maddu_big",  MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML, 0, 0);
`else
      issue(MADD, 32'd3, 32'd4, 1'b0);
      check("madd_off_busy", 64'(busy), 64'(0));
      read_hilo(v);
      check("madd_off_hilo", v, m_hilo);
      issue(MSUBU, 32'd5, 32'd5, 1'b0);
      check("msubu_off_busy", 64'(busy), 64'(0));
      read_hilo(v);
      check("msubu_off_hilo", v, m_hilo);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
